// File: rtl/fft_stage_scheduler_if.sv
// Handshake/status bundle between an FFT frame source, the stage scheduler and
// the cascaded butterfly stages. The scheduler side uses the slave modport.
interface fft_stage_scheduler_if #(
  parameter int NUM_STAGES = 4,
  parameter int STG_W      = 2
);
  logic                  in_valid;
  logic                  in_ready;
  logic                  abort;
  logic [NUM_STAGES-1:0] stage_done;
  logic [NUM_STAGES-1:0] stage_start;
  logic [STG_W-1:0]      cur_stage;
  logic                  busy;
  logic                  frame_done;
  logic [15:0]           frame_cnt;
  logic                  timeout_err;

  modport master (
    output in_valid, abort, stage_done,
    input  in_ready, stage_start, cur_stage, busy, frame_done, frame_cnt, timeout_err
  );

  modport slave (
    input  in_valid, abort, stage_done,
    output in_ready, stage_start, cur_stage, busy, frame_done, frame_cnt, timeout_err
  );
endinterface

// File: rtl/fft_stage_scheduler.sv
// Sequences NUM_STAGES cascaded FFT stages one after another per frame.
// Optional per-stage WAIT watchdog enabled by defining FFT_SCHED_WATCHDOG_EN.
module fft_stage_scheduler #(
  parameter int NUM_STAGES = 4,
  parameter int STG_W      = 2,
  parameter int TIMEOUT    = 1023
) (
  input logic                  clk,
  input logic                  rst,
  fft_stage_scheduler_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [STG_W-1:0] LAST_STAGE = STG_W'(NUM_STAGES - 1);

  state_t                state_q, state_d;
  logic [STG_W-1:0]      stage_q, stage_d;
  logic [15:0]           frame_cnt_q, frame_cnt_d;
  logic                  timeout_err_q, timeout_err_d;
  logic [NUM_STAGES-1:0] stage_start_q, stage_start_d;
  logic                  busy_q, busy_d;
  logic                  in_ready_q, in_ready_d;
  logic                  frame_done_q, frame_done_d;
  logic                  done_hit;
  logic                  wd_expired;

  // Only the running stage's completion is honoured; stray pulses are dropped.
  assign done_hit = bus.stage_done[stage_q];

`ifdef FFT_SCHED_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);

  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;

  assign wd_expired = (wd_cnt_q == WD_W'(TIMEOUT - 1));

  always_comb begin
    wd_cnt_d = wd_cnt_q;
    if (state_d == S_WAIT && state_q != S_WAIT) begin
      wd_cnt_d = '0;
    end else if (state_q == S_WAIT) begin
      wd_cnt_d = wd_cnt_q + WD_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt_q <= '0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
    end
  end
`else
  // Watchdog compiled out: constant false, so WAIT never gives up.
  assign wd_expired = (TIMEOUT < 0);
`endif

  always_comb begin
    state_d       = state_q;
    stage_d       = stage_q;
    frame_cnt_d   = frame_cnt_q;
    timeout_err_d = timeout_err_q;

    case (state_q)
      S_IDLE: begin
        stage_d = '0;
        if (bus.in_valid) begin
          state_d = S_START;
        end
      end
      S_START: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (done_hit) begin
          if (stage_q == LAST_STAGE) begin
            state_d     = S_DONE;
            frame_cnt_d = frame_cnt_q + 16'd1;
          end else begin
            state_d = S_START;
            stage_d = stage_q + STG_W'(1);
          end
        end else if (wd_expired) begin
          state_d       = S_ERR;
          timeout_err_d = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        stage_d = '0;
      end
      S_ERR: begin
        state_d = S_ERR;
      end
      default: begin
        state_d = S_IDLE;
        stage_d = '0;
      end
    endcase

    // Abort overrides everything above, including a same-edge stage completion.
    if (bus.abort) begin
      state_d       = S_IDLE;
      stage_d       = '0;
      frame_cnt_d   = frame_cnt_q;
      timeout_err_d = 1'b0;
    end
  end

  // Outputs are registered from the next state so they line up with state_q.
  for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_start
    assign stage_start_d[gi] = (state_d == S_START) && (stage_d == STG_W'(gi));
  end

  assign busy_d       = (state_d == S_START) || (state_d == S_WAIT) || (state_d == S_DONE);
  assign in_ready_d   = (state_d == S_IDLE);
  assign frame_done_d = (state_d == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      stage_q       <= '0;
      frame_cnt_q   <= '0;
      timeout_err_q <= 1'b0;
      stage_start_q <= '0;
      busy_q        <= 1'b0;
      in_ready_q    <= 1'b1;
      frame_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      stage_q       <= stage_d;
      frame_cnt_q   <= frame_cnt_d;
      timeout_err_q <= timeout_err_d;
      stage_start_q <= stage_start_d;
      busy_q        <= busy_d;
      in_ready_q    <= in_ready_d;
      frame_done_q  <= frame_done_d;
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.stage_start = stage_start_q;
  assign bus.cur_stage   = stage_q;
  assign bus.busy        = busy_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.frame_cnt   = frame_cnt_q;
  assign bus.timeout_err = timeout_err_q;

endmodule
